// File: rtl/ysyx_23060025_icache.sv
// ysyx_23060025_icache: direct-mapped read-only instruction cache; line refills use AXI4 INCR bursts.
// Only the valid bits are reset; the tag and data arrays hold whatever they last held.
module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_psel_i,
    input  logic [ADDR_WIDTH-1:0] ifu_paddr_i,
    output logic                  ifu_pready_o,
    output logic [DATA_WIDTH-1:0] ifu_prdata_o,
    output logic                  ifu_perr_o,
    input  logic                  fence_i_i,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int OFF_LSB = OFF_W + 2;
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_WIDTH - OFF_LSB - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, MISS_AR, MISS_R, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    logic                  pready_q, pready_d, perr_q, perr_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  err_q, err_d, inval_q, inval_d;
    logic [SETS-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

    logic [OFF_W-1:0] req_off, q_off;
    logic [IDX_W-1:0] req_idx, q_idx;
    logic [TAG_W-1:0] req_tag, q_tag;
    logic             hit, beat, last, beat_err, unused_ok;

    assign req_off  = ifu_paddr_i[OFF_LSB-1:2];
    assign req_idx  = ifu_paddr_i[OFF_LSB+IDX_W-1:OFF_LSB];
    assign req_tag  = ifu_paddr_i[ADDR_WIDTH-1:OFF_LSB+IDX_W];
    assign q_off    = addr_q[OFF_LSB-1:2];
    assign q_idx    = addr_q[OFF_LSB+IDX_W-1:OFF_LSB];
    assign q_tag    = addr_q[ADDR_WIDTH-1:OFF_LSB+IDX_W];
    // A fence in the request cycle wins over the lookup, forcing the miss path.
    assign hit      = valid_q[req_idx] && tag_q[req_idx] == req_tag && !fence_i_i;
    assign beat     = state_q == MISS_R && axi_rvalid_i;
    assign last     = beat && cnt_q == LAST;
    assign beat_err = err_q || axi_rresp_i != 2'b00;
    assign unused_ok = ^{ifu_paddr_i[1:0], addr_q[1:0], axi_rlast_i};

    assign ifu_pready_o  = pready_q;
    assign ifu_prdata_o  = prdata_q;
    assign ifu_perr_o    = perr_q;
    assign axi_araddr_o  = araddr_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;
    assign axi_arlen_o   = 8'(LINE_WORDS - 1);
    assign axi_arsize_o  = 3'b010;
    assign axi_arburst_o = 2'b01;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        araddr_d  = araddr_q;
        prdata_d  = prdata_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        perr_d    = perr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        inval_d   = inval_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: if (ifu_psel_i) begin
                addr_d = ifu_paddr_i;
                if (hit) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    prdata_d = data_q[req_idx][req_off];
                end else begin
                    state_d   = MISS_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = {ifu_paddr_i[ADDR_WIDTH-1:OFF_LSB], {OFF_LSB{1'b0}}};
                    cnt_d     = '0;
                end
            end
            MISS_AR: if (axi_arready_i) begin
                state_d   = MISS_R;
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            MISS_R: if (axi_rvalid_i) begin
                cnt_d    = cnt_q + 1'b1;
                err_d    = beat_err;
                prdata_d = cnt_q == q_off ? axi_rdata_i : prdata_q;
                if (cnt_q == LAST) begin
                    state_d        = RESP;
                    rready_d       = 1'b0;
                    pready_d       = 1'b1;
                    perr_d         = beat_err;
                    valid_d[q_idx] = !beat_err && !inval_q;
                end
            end
            default: begin
                state_d  = IDLE;
                pready_d = 1'b0;
                perr_d   = 1'b0;
                err_d    = 1'b0;
                inval_d  = 1'b0;
            end
        endcase
        if (fence_i_i) begin
            valid_d = '0;
            inval_d = inval_d || state_q == MISS_AR || state_q == MISS_R;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            araddr_q  <= '0;
            prdata_q  <= '0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            perr_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
            inval_q   <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            araddr_q  <= araddr_d;
            prdata_q  <= prdata_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            perr_q    <= perr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            err_q     <= err_d;
            inval_q   <= inval_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (beat) data_q[q_idx][cnt_q] <= axi_rdata_i;
        if (last) tag_q[q_idx] <= q_tag;
    end

    // The beat counter, not rlast, ends the burst; a disagreeing memory is a protocol bug.
    a_rlast: assert property (@(posedge clock) disable iff (!reset) beat |-> axi_rlast_i == (cnt_q == LAST));
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// tb_ysyx_23060025_icache: directed vector table plus hand sequences for fence, error, backpressure, reset.
module tb_ysyx_23060025_icache;
    logic        clock = 0, reset = 0;
    logic        psel = 0, fence = 0;
    logic [31:0] paddr = 0;
    logic        pready, perr, arvalid, rready;
    logic [31:0] prdata, araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready = 0, rvalid = 0, rlast = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0;

    int total = 0, bad = 0;
    int ar_cnt = 0, beats_done = 0, err_beat = -1, ar_delay = 0, beat_limit = 4;
    logic [31:0] last_ar = 0;

    always #5 clock = ~clock;

    ysyx_23060025_icache dut (
        .clock(clock), .reset(reset),
        .ifu_psel_i(psel), .ifu_paddr_i(paddr), .ifu_pready_o(pready),
        .ifu_prdata_o(prdata), .ifu_perr_o(perr), .fence_i_i(fence),
        .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_arlen_o(arlen), .axi_arsize_o(arsize), .axi_arburst_o(arburst),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory slave: optional AR stall, then a 4-beat burst (truncated by beat_limit).
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clock);
            if (reset && arvalid) begin
                a = araddr;
                for (int i = 0; i < ar_delay; i++) begin
                    @(negedge clock);
                    chk("ar_stable_valid", 32'(arvalid), 32'd1);
                    chk("ar_stable_addr", araddr, a);
                end
                chk("arlen", 32'(arlen), 32'd3);
                arready = 1; last_ar = a; ar_cnt++;
                @(negedge clock);
                arready = 0;
                for (int b = 0; b < 4; b++) begin
                    if (b >= beat_limit) break;
                    rvalid = 1; rdata = mem(a + 32'(4 * b));
                    rresp = (b == err_beat) ? 2'b10 : 2'b00; rlast = (b == 3);
                    @(negedge clock);
                    beats_done++;
                end
                rvalid = 0; rlast = 0; rresp = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit fz, output logic [31:0] d, output logic e, output int lat);
        @(negedge clock);
        psel = 1; paddr = a; fence = fz;
        lat = 0; d = 'x; e = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock); #1;
            if (fz) fence = 0;
            if (pready) begin lat = i; d = prdata; e = perr; break; end
        end
        psel = 0;
        if (lat == 0) chk("fetch_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        chk("pready_pulse", 32'(pready), 32'd0);
    endtask

    task automatic run(input logic [31:0] a, input bit fz, input int eb, input int miss, input logic pe);
        int n0 = ar_cnt;
        int lat;
        logic [31:0] d;
        logic e;
        err_beat = eb;
        fetch(a, fz, d, e, lat);
        chk("data", d, mem(a));
        chk("perr", 32'(e), 32'(pe));
        chk("ar_count", 32'(ar_cnt - n0), 32'(miss));
        if (miss != 0) chk("araddr", last_ar, {a[31:4], 4'b0});
        else chk("hit_latency", 32'(lat), 32'd1);
        err_beat = -1;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          eb;
        int          miss;
        logic        pe;
    } vec_t;

    initial begin
        vec_t tbl[10];
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        tbl[0] = '{32'h8000_0008, -1, 1, 1'b0};
        tbl[1] = '{32'h8000_000C, -1, 0, 1'b0};
        tbl[2] = '{32'h8000_0000, -1, 0, 1'b0};
        tbl[3] = '{32'h8000_0100, -1, 1, 1'b0};
        tbl[4] = '{32'h8000_0000, -1, 1, 1'b0};
        tbl[5] = '{32'h8000_0014, -1, 1, 1'b0};
        tbl[6] = '{32'h8000_0018, -1, 0, 1'b0};
        tbl[7] = '{32'h8000_0200,  1, 1, 1'b1};
        tbl[8] = '{32'h8000_0200, -1, 1, 1'b0};
        tbl[9] = '{32'h8000_0204, -1, 0, 1'b0};

        repeat (3) @(negedge clock);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        reset = 1;

        for (int i = 0; i < 10; i++) run(tbl[i].addr, 1'b0, tbl[i].eb, tbl[i].miss, tbl[i].pe);

        // Fence while idle drops every line.
        @(negedge clock); fence = 1;
        @(negedge clock); fence = 0;
        run(32'h8000_0204, 1'b0, -1, 1, 1'b0);

        // Fence during the refill: data still returned, line left invalid.
        fork
            run(32'h8000_0010, 1'b0, -1, 1, 1'b0);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clock);
                    if (rready) break;
                end
                fence = 1;
                @(negedge clock); fence = 0;
            end
        join
        run(32'h8000_0014, 1'b0, -1, 1, 1'b0);
        run(32'h8000_0018, 1'b0, -1, 0, 1'b0);

        // Fence together with a request that would otherwise hit.
        run(32'h8000_0018, 1'b1, -1, 1, 1'b0);
        run(32'h8000_001C, 1'b0, -1, 0, 1'b0);

        ar_delay = 5;
        run(32'h8000_0300, 1'b0, -1, 1, 1'b0);
        ar_delay = 0;

        // Reset asserted in the middle of a refill.
        beat_limit = 2; beats_done = 0;
        @(negedge clock); psel = 1; paddr = 32'h8000_0040;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (beats_done >= 2) break;
        end
        @(negedge clock);
        chk("midfill_rready", 32'(rready), 32'd1);
        reset = 0; #1;
        chk("async_rready", 32'(rready), 32'd0);
        chk("async_arvalid", 32'(arvalid), 32'd0);
        chk("async_pready", 32'(pready), 32'd0);
        chk("async_prdata", prdata, 32'd0);
        psel = 0;
        @(negedge clock); reset = 1; beat_limit = 4;
        run(32'h8000_0040, 1'b0, -1, 1, 1'b0);
        run(32'h8000_001C, 1'b0, -1, 1, 1'b0);
        run(32'h8000_0044, 1'b0, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
